// File: rtl/multi_way_rename_unit.sv
// ---------------------------------------------------------------------------
// multi_way_rename_unit
//
// Purpose:
//   N-wide register renaming for the out-of-order front end. Each cycle a
//   group of RENAME_WIDTH instructions is mapped from architectural to
//   physical registers. Destinations written by earlier lanes of the same
//   group are bypassed to later lanes. Physical registers come from a
//   circular free list.
//
//   Commit releases the old physical tag of each retiring writer back onto
//   the free list and updates a committed (retirement) map. A flush restores
//   the speculative map and the free-list head from that committed state in
//   a single cycle.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   rename_valid       rename group presented (all lanes fire together)
//   rename_ready       group accepted when rename_valid=1
//   lane_valid/we      per-lane instruction present / writes a destination
//   lane_src1/2, dst   lane-packed architectural register numbers
//   lane_phy_src1/2    renamed sources (combinational, same cycle)
//   lane_phy_dst       newly allocated destination (or current mapping)
//   lane_phy_old       previous mapping of lane_dst, carried to commit by ROB
//   commit_valid/we    per-lane commit; we=1 means it wrote a register
//   commit_arch_rd     committed architectural destination
//   commit_new/old_phy committed new and old physical tags
//   flush              discard all uncommitted renames
//   free_count         registered free-list occupancy
// ---------------------------------------------------------------------------
module multi_way_rename_unit #(
    parameter int ARCH_REG_NUM_WIDTH     = 5,
    parameter int PHYSICAL_REG_NUM_WIDTH = 6,
    parameter int RENAME_WIDTH           = 2,
    parameter int COMMIT_WIDTH           = 2
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           rename_valid,
    output logic                                           rename_ready,
    input  logic [RENAME_WIDTH-1:0]                        lane_valid,
    input  logic [RENAME_WIDTH-1:0]                        lane_we,
    input  logic [RENAME_WIDTH*ARCH_REG_NUM_WIDTH-1:0]     lane_src1,
    input  logic [RENAME_WIDTH*ARCH_REG_NUM_WIDTH-1:0]     lane_src2,
    input  logic [RENAME_WIDTH*ARCH_REG_NUM_WIDTH-1:0]     lane_dst,
    output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0] lane_phy_src1,
    output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0] lane_phy_src2,
    output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0] lane_phy_dst,
    output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0] lane_phy_old,
    input  logic [COMMIT_WIDTH-1:0]                        commit_valid,
    input  logic [COMMIT_WIDTH-1:0]                        commit_we,
    input  logic [COMMIT_WIDTH*ARCH_REG_NUM_WIDTH-1:0]     commit_arch_rd,
    input  logic [COMMIT_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0] commit_new_phy,
    input  logic [COMMIT_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0] commit_old_phy,
    input  logic                                           flush,
    output logic [PHYSICAL_REG_NUM_WIDTH:0]                free_count
);

    localparam int A         = ARCH_REG_NUM_WIDTH;
    localparam int P         = PHYSICAL_REG_NUM_WIDTH;
    localparam int NUM_ARCH  = 1 << A;
    localparam int NUM_PHY   = 1 << P;
    localparam int INIT_FREE = NUM_PHY - NUM_ARCH;

    typedef logic [A-1:0] arch_t;
    typedef logic [P-1:0] phy_t;
    typedef logic [P:0]   ptr_t;   // one extra bit so full and empty differ

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    phy_t r_spec_map   [NUM_ARCH];
    phy_t r_commit_map [NUM_ARCH];
    phy_t r_free_list  [NUM_PHY];
    ptr_t r_head;          // next tag to hand out
    ptr_t r_commit_head;   // head as seen by retired instructions only
    ptr_t r_tail;          // next slot for a released tag
    ptr_t r_free_count;

    // -----------------------------------------------------------------------
    // Rename-side combinational signals
    // -----------------------------------------------------------------------
    logic [RENAME_WIDTH-1:0] w_alloc;
    ptr_t                    w_alloc_cnt;
    phy_t                    w_new_phy  [RENAME_WIDTH];
    phy_t                    w_phy_src1 [RENAME_WIDTH];
    phy_t                    w_phy_src2 [RENAME_WIDTH];
    phy_t                    w_phy_old  [RENAME_WIDTH];
    logic                    w_fire;

    // -----------------------------------------------------------------------
    // Commit-side combinational signals
    // -----------------------------------------------------------------------
    logic [COMMIT_WIDTH-1:0] w_commit_en;
    phy_t                    w_push_idx [COMMIT_WIDTH];
    ptr_t                    w_commit_cnt;
    phy_t                    w_cmap_nxt [NUM_ARCH];
    ptr_t                    w_tail_nxt;
    ptr_t                    w_chead_nxt;
    ptr_t                    w_head_nxt;

    // The check uses the registered count, so tags released this cycle are
    // never handed out in the same cycle.
    assign rename_ready = !reset && !flush &&
                          (r_free_count >= ptr_t'(RENAME_WIDTH));
    assign w_fire       = rename_valid && rename_ready;

    // Allocation: allocating lane i takes the slot head + (number of
    // allocating lanes below it).
    always_comb begin
        ptr_t cnt;
        // NOTE: every always_comb output gets a default before any branch or
        // loop so no path leaves a value held, which would infer a latch.
        cnt = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            w_alloc[i]   = lane_valid[i] & lane_we[i] &
                           (lane_dst[i*A +: A] != arch_t'(0));
            w_new_phy[i] = r_free_list[r_head[P-1:0] + cnt[P-1:0]];
            cnt          = cnt + ptr_t'(w_alloc[i]);
        end
        w_alloc_cnt = cnt;
    end

    // Intra-group bypass: scanning older lanes in ascending order lets the
    // highest matching allocating lane win. An allocating lane never has
    // dst=x0, so an x0 source can never match and always reads P0 from map.
    always_comb begin
        phy_t s1;
        phy_t s2;
        phy_t old;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            s1  = r_spec_map[lane_src1[i*A +: A]];
            s2  = r_spec_map[lane_src2[i*A +: A]];
            old = r_spec_map[lane_dst[i*A +: A]];
            for (int j = 0; j < RENAME_WIDTH; j++) begin
                if (j < i && w_alloc[j]) begin
                    if (lane_dst[j*A +: A] == lane_src1[i*A +: A]) s1  = w_new_phy[j];
                    if (lane_dst[j*A +: A] == lane_src2[i*A +: A]) s2  = w_new_phy[j];
                    if (lane_dst[j*A +: A] == lane_dst[i*A +: A])  old = w_new_phy[j];
                end
            end
            w_phy_src1[i] = s1;
            w_phy_src2[i] = s2;
            w_phy_old[i]  = old;
        end
    end

    // Output drive; everything reads 0 while reset is held.
    always_comb begin
        lane_phy_src1 = '0;
        lane_phy_src2 = '0;
        lane_phy_dst  = '0;
        lane_phy_old  = '0;
        if (!reset) begin
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                lane_phy_src1[i*P +: P] = w_phy_src1[i];
                lane_phy_src2[i*P +: P] = w_phy_src2[i];
                lane_phy_old[i*P +: P]  = w_phy_old[i];
                lane_phy_dst[i*P +: P]  = w_alloc[i] ? w_new_phy[i] : w_phy_old[i];
            end
        end
    end

    assign free_count = reset ? '0 : r_free_count;

    // Commit: the next committed map is built here so that a flush in the
    // same cycle restores from a map that already includes these commits.
    always_comb begin
        ptr_t cnt;
        cnt        = '0;
        w_cmap_nxt = r_commit_map;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            w_commit_en[j] = commit_valid[j] & commit_we[j] &
                             (commit_arch_rd[j*A +: A] != arch_t'(0));
            w_push_idx[j]  = r_tail[P-1:0] + cnt[P-1:0];
            if (w_commit_en[j]) begin
                w_cmap_nxt[commit_arch_rd[j*A +: A]] = commit_new_phy[j*P +: P];
            end
            cnt = cnt + ptr_t'(w_commit_en[j]);
        end
        w_commit_cnt = cnt;
    end

    assign w_tail_nxt  = r_tail + w_commit_cnt;
    assign w_chead_nxt = r_commit_head + w_commit_cnt;
    assign w_head_nxt  = flush  ? w_chead_nxt :
                         w_fire ? (r_head + w_alloc_cnt) : r_head;

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the free list and both maps are architecturally visible
            // at reset (identity maps, ascending free tags), so these arrays
            // are reset explicitly rather than left as uninitialised RAM.
            for (int i = 0; i < NUM_ARCH; i++) begin
                r_spec_map[i]   <= phy_t'(i);
                r_commit_map[i] <= phy_t'(i);
            end
            for (int i = 0; i < NUM_PHY; i++) begin
                r_free_list[i] <= (i < INIT_FREE) ? phy_t'(i + NUM_ARCH) : phy_t'(0);
            end
            r_head        <= '0;
            r_commit_head <= '0;
            r_tail        <= ptr_t'(INIT_FREE);
            r_free_count  <= ptr_t'(INIT_FREE);
        end else begin
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (w_commit_en[j]) begin
                    r_free_list[w_push_idx[j]] <= commit_old_phy[j*P +: P];
                end
            end
            r_commit_map  <= w_cmap_nxt;
            r_tail        <= w_tail_nxt;
            r_commit_head <= w_chead_nxt;
            r_head        <= w_head_nxt;
            r_free_count  <= w_tail_nxt - w_head_nxt;

            if (flush) begin
                r_spec_map <= w_cmap_nxt;
            end else if (w_fire) begin
                // NOTE: non-blocking writes in ascending lane order; when two
                // lanes share a dst the later write is the one that lands.
                for (int i = 0; i < RENAME_WIDTH; i++) begin
                    if (w_alloc[i]) begin
                        r_spec_map[lane_dst[i*A +: A]] <= w_new_phy[i];
                    end
                end
            end
        end
    end

    // Conservation guards: these can only trip on a broken ROB/commit stream.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (r_free_count <= ptr_t'(INIT_FREE));
            assert (!w_fire || (w_alloc_cnt <= r_free_count));
        end
    end

endmodule

// File: tb/tb_multi_way_rename_unit.sv
// ---------------------------------------------------------------------------
// tb_multi_way_rename_unit
//
// Directed scenarios followed by random traffic. The reference model treats
// the rename group as a short sequential program over an architectural map,
// keeps the free list as a FIFO of tags, and keeps a ROB of uncommitted
// allocations; a flush returns those uncommitted tags to the front of the
// FIFO in allocation order.
// ---------------------------------------------------------------------------
module tb_multi_way_rename_unit;

    localparam int A         = 5;
    localparam int P         = 6;
    localparam int RW        = 2;
    localparam int CW        = 2;
    localparam int NA        = 1 << A;
    localparam int INIT_FREE = (1 << P) - NA;

    logic              clk = 1'b0;
    logic              reset;
    logic              rename_valid;
    logic              rename_ready;
    logic [RW-1:0]     lane_valid, lane_we;
    logic [RW*A-1:0]   lane_src1, lane_src2, lane_dst;
    logic [RW*P-1:0]   lane_phy_src1, lane_phy_src2, lane_phy_dst, lane_phy_old;
    logic [CW-1:0]     commit_valid, commit_we;
    logic [CW*A-1:0]   commit_arch_rd;
    logic [CW*P-1:0]   commit_new_phy, commit_old_phy;
    logic              flush;
    logic [P:0]        free_count;

    always #5 clk = ~clk;

    multi_way_rename_unit #(
        .ARCH_REG_NUM_WIDTH(A), .PHYSICAL_REG_NUM_WIDTH(P),
        .RENAME_WIDTH(RW), .COMMIT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .rename_valid(rename_valid), .rename_ready(rename_ready),
        .lane_valid(lane_valid), .lane_we(lane_we),
        .lane_src1(lane_src1), .lane_src2(lane_src2), .lane_dst(lane_dst),
        .lane_phy_src1(lane_phy_src1), .lane_phy_src2(lane_phy_src2),
        .lane_phy_dst(lane_phy_dst), .lane_phy_old(lane_phy_old),
        .commit_valid(commit_valid), .commit_we(commit_we),
        .commit_arch_rd(commit_arch_rd),
        .commit_new_phy(commit_new_phy), .commit_old_phy(commit_old_phy),
        .flush(flush), .free_count(free_count)
    );

    typedef struct {
        int rd;
        int newp;
        int oldp;
    } rob_t;

    int   m_spec [NA];
    int   m_cmt  [NA];
    int   m_free [$];
    rob_t rob    [$];

    int o_s1 [RW];
    int o_s2 [RW];
    int o_dst[RW];
    int o_old[RW];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < NA; i++) begin
            m_spec[i] = i;
            m_cmt[i]  = i;
        end
        m_free.delete();
        for (int i = 0; i < INIT_FREE; i++) m_free.push_back(NA + i);
        rob.delete();
    endtask

    task automatic clear_in();
        rename_valid   = 1'b0;
        lane_valid     = '0;
        lane_we        = '0;
        lane_src1      = '0;
        lane_src2      = '0;
        lane_dst       = '0;
        commit_valid   = '0;
        commit_we      = '0;
        commit_arch_rd = '0;
        commit_new_phy = '0;
        commit_old_phy = '0;
        flush          = 1'b0;
    endtask

    task automatic set_lane(input int i, input bit we, input int s1, input int s2, input int d);
        lane_valid[i]        = 1'b1;
        lane_we[i]           = we;
        lane_src1[i*A +: A]  = A'(s1);
        lane_src2[i*A +: A]  = A'(s2);
        lane_dst[i*A +: A]   = A'(d);
    endtask

    task automatic set_cmt_rob(input int j, input int idx);
        commit_valid[j]          = 1'b1;
        commit_we[j]             = 1'b1;
        commit_arch_rd[j*A +: A] = A'(rob[idx].rd);
        commit_new_phy[j*P +: P] = P'(rob[idx].newp);
        commit_old_phy[j*P +: P] = P'(rob[idx].oldp);
    endtask

    // One clock: inputs are already driven (just after a negedge). Checks the
    // registered count, the handshake and the renamed lanes, then advances
    // the model across the posedge and returns at the next negedge.
    task automatic step();
        int   tmp[NA];
        int   k;
        bit   exp_ready;
        bit   fire;
        rob_t fresh[$];
        #1;
        check("free_count", free_count, m_free.size());
        exp_ready = !flush && (m_free.size() >= RW);
        check("rename_ready", rename_ready, exp_ready);
        fire = rename_valid && exp_ready;
        for (int i = 0; i < RW; i++) begin
            o_s1[i]  = int'(lane_phy_src1[i*P +: P]);
            o_s2[i]  = int'(lane_phy_src2[i*P +: P]);
            o_dst[i] = int'(lane_phy_dst[i*P +: P]);
            o_old[i] = int'(lane_phy_old[i*P +: P]);
        end
        tmp = m_spec;
        k   = 0;
        if (fire) begin
            for (int i = 0; i < RW; i++) begin
                int  s1, s2, d, e_dst, e_old;
                bit  alloc;
                s1    = int'(lane_src1[i*A +: A]);
                s2    = int'(lane_src2[i*A +: A]);
                d     = int'(lane_dst[i*A +: A]);
                alloc = lane_valid[i] && lane_we[i] && (d != 0);
                e_old = tmp[d];
                e_dst = alloc ? m_free[k] : e_old;
                check($sformatf("lane%0d_src1", i), lane_phy_src1[i*P +: P], tmp[s1]);
                check($sformatf("lane%0d_src2", i), lane_phy_src2[i*P +: P], tmp[s2]);
                check($sformatf("lane%0d_old", i),  lane_phy_old[i*P +: P],  e_old);
                check($sformatf("lane%0d_dst", i),  lane_phy_dst[i*P +: P],  e_dst);
                if (alloc) begin
                    tmp[d] = e_dst;
                    fresh.push_back('{rd: d, newp: e_dst, oldp: e_old});
                    k++;
                end
            end
            m_spec = tmp;
            for (int i = 0; i < k; i++) void'(m_free.pop_front());
        end
        for (int j = 0; j < CW; j++) begin
            int rd;
            rd = int'(commit_arch_rd[j*A +: A]);
            if (commit_valid[j] && commit_we[j] && rd != 0) begin
                m_cmt[rd] = int'(commit_new_phy[j*P +: P]);
                m_free.push_back(int'(commit_old_phy[j*P +: P]));
                if (rob.size() > 0) void'(rob.pop_front());
            end
        end
        foreach (fresh[i]) rob.push_back(fresh[i]);
        if (flush) begin
            m_spec = m_cmt;
            for (int i = rob.size() - 1; i >= 0; i--) m_free.push_front(rob[i].newp);
            rob.delete();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_in();
        @(negedge clk);
        #1;
        check("rst_ready", rename_ready, 0);
        check("rst_free_count", free_count, 0);
        check("rst_dst", lane_phy_dst, 0);
        @(negedge clk);
        reset = 1'b0;
        reset_model();
    endtask

    task automatic group(input int d0, input int d1);
        clear_in();
        rename_valid = 1'b1;
        set_lane(0, 1'b1, $urandom_range(0, NA-1), $urandom_range(0, NA-1), d0);
        set_lane(1, 1'b1, $urandom_range(0, NA-1), $urandom_range(0, NA-1), d1);
        step();
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        do_reset();

        // T1: intra-group bypass on the first group after reset.
        clear_in();
        rename_valid = 1'b1;
        set_lane(0, 1'b1, 2, 3, 1);
        set_lane(1, 1'b1, 1, 1, 4);
        step();
        check("t1_l0_src1", o_s1[0], 2);
        check("t1_l0_src2", o_s2[0], 3);
        check("t1_l0_dst",  o_dst[0], 32);
        check("t1_l0_old",  o_old[0], 1);
        check("t1_l1_src1", o_s1[1], 32);
        check("t1_l1_src2", o_s2[1], 32);
        check("t1_l1_dst",  o_dst[1], 33);
        check("t1_l1_old",  o_old[1], 4);
        check("t1_free_count", free_count, 30);

        // T2: x0 destination and an invalid lane allocate nothing.
        do_reset();
        clear_in();
        rename_valid = 1'b1;
        set_lane(0, 1'b1, 7, 0, 0);
        step();
        check("t2_dst", o_dst[0], 0);
        check("t2_old", o_old[0], 0);
        check("t2_free_count", free_count, 32);
        group(1, 2);
        check("t2_head_kept", o_dst[0], 32);

        // T3: exhaustion, then recovery through two single commits.
        do_reset();
        group(1, 4);
        for (int g = 1; g < 16; g++) group($urandom_range(1, NA-1), $urandom_range(1, NA-1));
        check("t3_empty", free_count, 0);
        clear_in();
        rename_valid = 1'b1;
        set_lane(0, 1'b1, 1, 2, 3);
        set_cmt_rob(0, 0);
        step();
        check("t3_one_free", free_count, 1);
        clear_in();
        set_cmt_rob(0, 0);
        #1;
        check("t3_ready_low", rename_ready, 0);
        step();
        check("t3_two_free", free_count, 2);
        group(5, 6);
        check("t3_realloc_p1", o_dst[0], 1);

        // T4: flush while two commits retire.
        do_reset();
        group(1, 2);
        group(3, 4);
        group(5, 6);
        clear_in();
        set_cmt_rob(0, 0);
        set_cmt_rob(1, 1);
        flush = 1'b1;
        step();
        check("t4_free_count", free_count, 32);
        clear_in();
        rename_valid = 1'b1;
        set_lane(0, 1'b1, 1, 2, 7);
        set_lane(1, 1'b1, 3, 4, 8);
        step();
        check("t4_x1", o_s1[0], 32);
        check("t4_x2", o_s2[0], 33);
        check("t4_x3", o_s1[1], 3);
        check("t4_next_alloc", o_dst[0], 34);

        // T5: rename with two free tags while a commit releases P5.
        do_reset();
        group(5, 6);
        for (int g = 1; g < 15; g++) group($urandom_range(1, NA-1), $urandom_range(1, NA-1));
        check("t5_two_free", free_count, 2);
        clear_in();
        rename_valid = 1'b1;
        set_lane(0, 1'b1, 1, 2, 7);
        set_lane(1, 1'b1, 3, 4, 8);
        set_cmt_rob(0, 0);
        step();
        check("t5_dst0", o_dst[0], 62);
        check("t5_dst1", o_dst[1], 63);
        check("t5_free_count", free_count, 1);
        clear_in();
        #1;
        check("t5_ready_low", rename_ready, 0);

        // Random traffic, commits drawn in order from the model ROB.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int used;
            clear_in();
            rename_valid = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < RW; i++) begin
                if ($urandom_range(0, 4) != 0) begin
                    set_lane(i, 1'($urandom_range(0, 3) != 0),
                             $urandom_range(0, NA-1), $urandom_range(0, NA-1),
                             ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, NA-1));
                end
            end
            used = 0;
            for (int j = 0; j < CW; j++) begin
                if (used < rob.size() && $urandom_range(0, 1) == 1) begin
                    set_cmt_rob(j, used);
                    used++;
                end else begin
                    commit_valid[j]          = 1'($urandom_range(0, 1));
                    commit_we[j]             = 1'($urandom_range(0, 1));
                    commit_arch_rd[j*A +: A] = commit_we[j] ? A'(0) : A'($urandom_range(0, NA-1));
                    commit_new_phy[j*P +: P] = P'($urandom_range(0, 63));
                    commit_old_phy[j*P +: P] = P'($urandom_range(0, 63));
                end
            end
            flush = ($urandom_range(0, 24) == 0);
            step();
        end

        // T6: reset dropped in mid-stream with rename and commits pending.
        clear_in();
        rename_valid = 1'b1;
        set_lane(0, 1'b1, 1, 2, 3);
        set_lane(1, 1'b1, 4, 5, 6);
        commit_valid = 2'b11;
        commit_we    = 2'b11;
        commit_arch_rd = {A'(2), A'(1)};
        reset = 1'b1;
        #1;
        check("t6_ready_low", rename_ready, 0);
        check("t6_src_zero", lane_phy_src1, 0);
        @(negedge clk);
        reset = 1'b0;
        reset_model();
        clear_in();
        #1;
        check("t6_free_count", free_count, 32);
        rename_valid = 1'b1;
        set_lane(0, 1'b1, 9, 17, 0);
        set_lane(1, 1'b1, 31, 6, 0);
        step();
        check("t6_map_x9",  o_s1[0], 9);
        check("t6_map_x17", o_s2[0], 17);
        check("t6_map_x31", o_s1[1], 31);
        check("t6_map_x6",  o_s2[1], 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_way_rename_unit.md
Name: multi_way_rename_unit

Overview:
N-wide register renaming unit for the OOO front end. It maps RENAME_WIDTH architectural instructions per cycle to physical registers, including intra-group dependency bypass. Committed instructions release physical registers through a COMMIT_WIDTH-wide port into a circular free list. A committed (retirement) map table lets a single-cycle flush restore the speculative map and free list on branch mispredict or exception.

Parameters:
ARCH_REG_NUM_WIDTH, 5, log2 of architectural register count (x0 is hardwired zero).
PHYSICAL_REG_NUM_WIDTH, 6, log2 of physical register count; must be greater than ARCH_REG_NUM_WIDTH.
RENAME_WIDTH, 2, rename lanes per cycle (1..4).
COMMIT_WIDTH, 2, commit lanes per cycle (1..4).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
rename_valid  in  1  rename group presented; all lanes fire together
rename_ready  out  1  group accepted this cycle when rename_valid=1
lane_valid  in  RENAME_WIDTH  per-lane instruction present
lane_we  in  RENAME_WIDTH  per-lane writes a destination
lane_src1, lane_src2, lane_dst  in  RENAME_WIDTH*ARCH_REG_NUM_WIDTH  architectural register numbers, lane-packed
lane_phy_src1, lane_phy_src2  out  RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH  renamed sources
lane_phy_dst  out  RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH  newly allocated destination
lane_phy_old  out  RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH  previous mapping of lane_dst; the ROB carries it to commit
commit_valid, commit_we  in  COMMIT_WIDTH  per-lane commit; commit_we=1 means the instruction wrote a register
commit_arch_rd  in  COMMIT_WIDTH*ARCH_REG_NUM_WIDTH  committed architectural destination
commit_new_phy, commit_old_phy  in  COMMIT_WIDTH*PHYSICAL_REG_NUM_WIDTH  committed new and old physical tags
flush  in  1  discard all uncommitted renames
free_count  out  PHYSICAL_REG_NUM_WIDTH+1  registered free-list occupancy

Behaviour:
- Reset:
  - Spec map and committed map: map[i]=i.
  - Free list holds P(2^ARCH_REG_NUM_WIDTH) .. P(2^PHYSICAL_REG_NUM_WIDTH - 1) in ascending order.
  - head=commit_head=0; tail=free_count=2^PHY-2^ARCH.
  - rename_ready=0 while reset is asserted. All outputs are 0 during reset.
- Free list:
  - Circular array of depth 2^PHYSICAL_REG_NUM_WIDTH.
  - head, commit_head and tail are PHYSICAL_REG_NUM_WIDTH+1 bits wide and wrap modulo 2^(PHY+1).
  - free_count = tail - head.
- Allocating lane: lane_valid & lane_we & (lane_dst!=0).
- rename_ready = !flush && free_count >= RENAME_WIDTH. The check uses registered free_count; registers pushed this cycle are not poppable this cycle.
- Fire = rename_valid & rename_ready. Outputs are combinational in the same cycle (0 latency); state updates at posedge clk.
- Allocation order: allocating lane i takes free_list[head + k], where k is the number of allocating lanes below i. head advances by the total number of allocating lanes.
- Non-allocating lane: lane_phy_dst = lane_phy_old = current mapping of lane_dst (P0 when lane_dst=x0).
- Intra-group bypass:
  - lane i src (nonzero) matching the dst of an allocating lane j<i uses the new phy of the highest such j; otherwise it uses the spec map.
  - lane_phy_old follows the same rule.
  - src=x0 always returns the map entry for x0 (P0).
- Spec map update: for each allocating lane in ascending order, the highest lane wins on duplicate dst.
- Commit, per valid lane with commit_we & commit_arch_rd!=0, in lane order:
  - committed_map[rd] <= commit_new_phy (highest lane wins).
  - push commit_old_phy at tail.
  - commit_head advances by one.
  - Lanes with commit_we=0 or rd=x0 cause no state change.
- Flush, taking effect at the clock edge:
  - spec map <= committed map including same-cycle commits.
  - head <= commit_head including same-cycle advances.
  - Same-cycle commits are fully applied. rename_ready=0 during flush, so no allocation occurs.
- Overflow/underflow are impossible by conservation. A simulation assertion fires if free_count exceeds 2^PHY-2^ARCH or a pop occurs with insufficient entries.
- Reset mid-operation immediately returns all state to the reset values, regardless of pending commits or renames.

Test Plan:
1. After reset, one group: lane0 x1<=x2,x3 (we); lane1 x4<=x1,x1 (we) -> lane0 src P2,P3, dst P32, old P1; lane1 src P32,P32, dst P33, old P4; next-cycle free_count 30.
2. Lane0 we with dst x0, lane1 invalid -> no allocation; lane_phy_dst=lane_phy_old=P0; free_count stays 32; head unchanged.
3. Exhaustion: 16 groups of two allocating lanes -> free_count 0, rename_ready 0. One commit (old P1) -> free_count 1, ready still 0. Second commit (old P4) -> free_count 2, ready 1; next allocation is P1.
4. Flush recovery: after reset rename 3 groups (P32..P37 to x1..x6). Commit lanes (x1,P32,old P1) and (x2,P33,old P2) while flush=1. Then committed/spec map x1=P32, x2=P33, x3=P3; free_count 32; next allocation P34.
5. Same-cycle rename and commit: free_count=2, rename two allocating lanes while committing one (old P5) -> rename fires using P(head), P(head+1); next free_count 1; P5 not allocated in that cycle.
6. Reset asserted mid-stream with rename_valid=1 and commit_valid=11 -> rename_ready=0 immediately; after release the maps are identity and free_count=32.
